// File: rtl/i_mem_fill_responder_pkg.sv
// Shared types and defaults for the instruction-memory side of the IFU cache-fill protocol.
// A fill moves one 16-byte cache line as four 32-bit SRAM beats.
package i_mem_fill_responder_pkg;

  localparam int CL_WIDTH        = 128;
  localparam int IMEM_WORDS      = 4096;
  localparam int IMEM_RD_LATENCY = 2;

  typedef struct packed {
    logic        fill_requested_address_valid;
    logic [31:0] fill_requested_address;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic                valid;
    logic [31:0]         address;
    logic [CL_WIDTH-1:0] filled_instruction;
  } t_i_mem2cache_rsp;

  typedef enum logic [2:0] {
    IMEM_IDLE,
    IMEM_WAIT_LAT,
    IMEM_READ,
    IMEM_DRAIN,
    IMEM_RESP
  } t_imem_states;

endpackage

// File: rtl/i_mem_fill_responder_sram.sv
// Single-port MEM_WORDS x 32 synchronous-read RAM. A write owns the port for its
// cycle; the read register keeps its old value then, so rdata is not meaningful after a write.
module i_mem_fill_responder_sram
  import i_mem_fill_responder_pkg::*;
#(
  parameter int MEM_WORDS = IMEM_WORDS
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic                         re,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/i_mem_fill_responder.sv
// Instruction-memory fill responder: reads the aligned 16B line containing the
// requested address one word per cycle and presents it to the cache, plus a program-load write port.
module i_mem_fill_responder
  import i_mem_fill_responder_pkg::*;
#(
  parameter int MEM_WORDS  = IMEM_WORDS,
  parameter int RD_LATENCY = IMEM_RD_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  t_cache2i_mem_req cache2i_mem_req,
  output t_i_mem2cache_rsp i_mem2cache_rsp,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             overlap_err
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  t_imem_states        state;
  t_imem_states        next_state;
  logic                req_valid;
  logic                accept;
  logic                issue;
  logic [LAT_W-1:0]    lat_cnt;
  logic [1:0]          beat;
  logic [31:0]         req_addr;
  logic                vld_p1;
  logic [1:0]          beat_p1;
  logic [AW-1:0]       ram_addr;
  logic [31:0]         rdata;
  logic [31:0]         rsp_address;
  logic [CL_WIDTH-1:0] rsp_line;
  logic                unused_bits;

  function automatic logic [AW-1:0] word_index(input logic [31:0] a);
    return a[AW+1:2];
  endfunction

  function automatic logic [AW-1:0] beat_index(input logic [31:0] line_addr, input logic [1:0] k);
    return {line_addr[AW+1:4], k};
  endfunction

  assign req_valid   = cache2i_mem_req.fill_requested_address_valid;
  assign unused_bits = ^{wr_addr[31:AW+2], wr_addr[1:0]};

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    issue      = 1'b0;
    unique case (state)
      IMEM_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          next_state = (RD_LATENCY > 0) ? IMEM_WAIT_LAT : IMEM_READ;
        end
      end
      IMEM_WAIT_LAT: begin
        if (lat_cnt == LAT_W'(RD_LATENCY - 1)) begin
          next_state = IMEM_READ;
        end
      end
      IMEM_READ: begin
        // A program-load write steals the port; the beat retries next cycle.
        if (!wr_en) begin
          issue = 1'b1;
          if (beat == 2'd3) begin
            next_state = IMEM_DRAIN;
          end
        end
      end
      IMEM_DRAIN: next_state = IMEM_RESP;
      IMEM_RESP:  next_state = IMEM_IDLE;
      default:    next_state = IMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IMEM_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt     <= '0;
      beat        <= '0;
      vld_p1      <= 1'b0;
      overlap_err <= 1'b0;
    end else begin
      if (accept) begin
        lat_cnt <= '0;
      end else if (state == IMEM_WAIT_LAT) begin
        lat_cnt <= lat_cnt + 1'b1;
      end
      if (accept) begin
        beat <= '0;
      end else if (issue) begin
        beat <= beat + 1'b1;
      end
      vld_p1 <= issue;
      if (req_valid && (state != IMEM_IDLE)) begin
        overlap_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= cache2i_mem_req.fill_requested_address;
    end
    beat_p1 <= beat;
  end

  assign ram_addr = wr_en ? word_index(wr_addr) : beat_index(req_addr, beat);

  i_mem_fill_responder_sram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_sram (
    .clk  (clk),
    .we   (wr_en),
    .re   (issue),
    .addr (ram_addr),
    .wdata(wr_data),
    .rdata(rdata)
  );

  // Stage p1: SRAM data of the beat issued last cycle lands in its line slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_address <= '0;
      rsp_line    <= '0;
    end else if (vld_p1) begin
      rsp_line[32*beat_p1 +: 32] <= rdata;
      if (beat_p1 == 2'd0) begin
        rsp_address <= req_addr;
      end
    end
  end

  assign i_mem2cache_rsp = '{valid:              (state == IMEM_RESP),
                             address:            rsp_address,
                             filled_instruction: rsp_line};

endmodule
